mult_stage_ctrl: RTL
====================

MULT_STAGE_CTRL -- requirements
Module: mult_stage_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: multiplier operand B width; legal range 2..16.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: clock cycles allowed for the combinational multiplier to settle; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: upstream offers an operand pair.
REQ-006 SHALL have port in_ready, output, 1: block accepts an operand pair this cycle.
REQ-007 SHALL have port in_a, input, 4: multiplicand.
REQ-008 SHALL have port in_b, input, N: multiplier.
REQ-009 SHALL have port mult_a, output, 4: registered multiplicand driven to the external 4xN multiplier.
REQ-010 SHALL have port mult_b, output, N: registered multiplier driven to the external 4xN multiplier.
REQ-011 SHALL have port mult_p, input, N+4: product returned by the external multiplier.
REQ-012 SHALL have port out_valid, output, 1: captured product available.
REQ-013 SHALL have port out_ready, input, 1: downstream consumes the product.
REQ-014 SHALL have port out_p, output, N+4: registered product.
REQ-015 SHALL have port chk_err, output, 1: self-check mismatch flag (see Configuration).

Function
REQ-016 SHALL implement states IDLE, SETTLE and DONE.
REQ-017 SHALL assert in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-018 SHALL accept a pair on any edge where in_valid and in_ready are both high, load in_a/in_b into mult_a/mult_b, load the settle counter with SETTLE_CYCLES-1, and enter SETTLE.
REQ-019 SHALL hold mult_a/mult_b constant from acceptance until the next acceptance.
REQ-020 SHALL, in SETTLE, decrement the counter each cycle and, on the edge where the counter equals 0, capture mult_p into out_p and enter DONE.
REQ-021 SHALL assert out_valid exactly SETTLE_CYCLES cycles after the acceptance edge; out_valid is high only in DONE.
REQ-022 SHALL hold out_valid and out_p stable in DONE until out_ready is high.
REQ-023 SHALL, in DONE with out_ready high, go to SETTLE if in_valid is high (back-to-back acceptance of the new pair in the same cycle), otherwise go to IDLE.
REQ-024 SHALL ignore in_valid in SETTLE; in_a/in_b changes there have no effect.
REQ-025 SHALL treat out_ready high outside DONE as no-op.

Reset
REQ-026 SHALL, on reset high at a rising edge, enter IDLE and clear mult_a, mult_b, out_p, the counter, out_valid and chk_err to 0, regardless of the current state.
REQ-027 SHALL discard any in-flight operation on reset; no out_valid follows it.
REQ-028 SHALL give reset priority over every handshake event in the same cycle.

Configuration
REQ-029 SHALL compile the self-check under macro MULT_STAGE_SELFCHECK_EN.
REQ-030 SHALL, with the macro defined, compare the captured product against the behavioural mult_a*mult_b at capture, set chk_err sticky on mismatch, and clear it only on reset.
REQ-031 SHALL, without the macro, tie chk_err to 0 and contain no behavioural multiply.

Structure
REQ-032 SHALL take the state encoding typedef (IDLE=0, SETTLE=1, DONE=2) and counter width constant (4 bits) from shared package mult_pkg.
REQ-033 SHALL place the settle counter in sub-module settle_counter (load, decrement, zero flag).
REQ-034 SHALL NOT instantiate the multiplier; the bench or parent connects mult_a/mult_b/mult_p to multiplier4xN2 with matching N.

Verification
REQ-035 SHALL cover: N=4, SETTLE_CYCLES=4, reset then A=15, B=15 accepted -> out_valid high 4 cycles later, out_p=225.
REQ-036 SHALL cover: A=9, B=6, out_ready held low 5 cycles in DONE -> out_p=54 and out_valid held throughout; one transfer on release.
REQ-037 SHALL cover: DONE with out_ready=1 and in_valid=1 (A=3, B=7) -> same-cycle acceptance, next out_p=21 after 4 cycles, no IDLE cycle.
REQ-038 SHALL cover: reset asserted 2 cycles into SETTLE -> IDLE, all outputs 0, no out_valid afterwards.
REQ-039 SHALL cover: in_a changed from 5 to 12 during SETTLE (B=2) -> out_p=10.
REQ-040 SHALL cover, with MULT_STAGE_SELFCHECK_EN and mult_p forced to bit 0 stuck-at-1 for A=2, B=2 -> out_p=5, chk_err=1 and sticky until reset.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier stage controller.
//   state_e : controller state encoding (idle = 0, settle = 1, done = 2)
//   CntW    : width of the settle counter
package mult_pkg;

    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StDone   = 2'd2
    } state_e;

endpackage

// File: rtl/mult_stage_ctrl_settle_counter.sv
// Settle counter: loadable down-counter with a zero flag.
// Ports:
//   clk_i      : clock
//   reset_i    : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (has priority over decrement)
//   load_val_i : value to load
//   dec_i      : decrement by one; saturates at zero
//   zero_o     : count is zero
module settle_counter
    import mult_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    input  logic            dec_i,
    output logic            zero_o
);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mult_stage_ctrl.sv
// Controller that registers an operand pair for an external 4xN combinational
// multiplier, waits SETTLE_CYCLES clocks for it to settle, then captures the
// product and offers it downstream with a valid/ready handshake.
// Optional self-check compiled in with macro MULT_STAGE_SELFCHECK_EN.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake, in_a (4 bits), in_b (N bits)
//   mult_a/mult_b         : registered operands to the external multiplier
//   mult_p                : product from the external multiplier
//   out_valid/out_ready   : product handshake, out_p (N+4 bits)
//   chk_err               : sticky self-check mismatch (0 when check not built)
module mult_stage_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned N             = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     in_a,
    input  logic [N-1:0]   in_b,
    output logic [3:0]     mult_a,
    output logic [N-1:0]   mult_b,
    input  logic [N+3:0]   mult_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+3:0]   out_p,
    output logic           chk_err
);

    localparam int unsigned PW = N + 4;
    localparam logic [CntW-1:0] LoadVal = CntW'(SETTLE_CYCLES - 1);

    state_e        state_q;
    logic [3:0]    mult_a_q;
    logic [N-1:0]  mult_b_q;
    logic [PW-1:0] out_p_q;
    logic          out_valid_q;

    logic accept;
    logic capture;
    logic cnt_zero;

    // in_ready depends on out_ready so that a done slot can be refilled in the
    // same cycle its product is consumed.
    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept   = in_valid && in_ready;
    assign capture  = (state_q == StSettle) && cnt_zero;

    settle_counter u_settle_counter (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (accept),
        .load_val_i (LoadVal),
        .dec_i      (state_q == StSettle),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        mult_a_q <= in_a;
                        mult_b_q <= in_b;
                        state_q  <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_zero) begin
                        out_p_q     <= mult_p;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            mult_a_q <= in_a;
                            mult_b_q <= in_b;
                            state_q  <= StSettle;
                        end else begin
                            state_q  <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mult_a    = mult_a_q;
    assign mult_b    = mult_b_q;
    assign out_p     = out_p_q;
    assign out_valid = out_valid_q;

`ifdef MULT_STAGE_SELFCHECK_EN
    logic [PW-1:0] ref_p;
    logic          chk_err_q;

    assign ref_p = PW'(mult_a_q) * PW'(mult_b_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_err_q <= 1'b0;
        end else if (capture && (mult_p != ref_p)) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    // capture only feeds the self-check; keep it referenced.
    logic unused_capture;
    assign unused_capture = capture;
    assign chk_err = 1'b0;
`endif

endmodule
